mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MAX_WAIT, default 255: max cycles a memory access may wait for gnt plus rvalid before abort.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ex_valid_i  in  1  EX/MEM slot holds a real instruction.
REQ-005 ex_alu_result_i  in  32  ALU result / effective address.
REQ-006 ex_store_data_i  in  32  rs2 store data.
REQ-007 ex_rd_addr_i  in  5; ex_pc_plus4_i  in  32; ex_reg_we_i  in  1; ex_wb_mux_sel_i  in  2  (00 ALU, 01 Mem, 10 PC+4).
REQ-008 ex_mem_read_i  in  1; ex_mem_write_i  in  1; ex_funct3_i  in  3  access size/sign.
REQ-009 mem_stall_o  out  1  freeze upstream stages; EX/MEM inputs held stable while high.
REQ-010 dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32  word-aligned; dmem_wdata_o  out  32; dmem_be_o  out  4.
REQ-011 dmem_gnt_i  in  1  request accepted; dmem_rvalid_i  in  1; dmem_rdata_i  in  32  read word.
REQ-012 wb_mem_rdata_o, wb_alu_result_o, wb_pc_plus4_o  out  32; wb_rd_addr_o  out  5; wb_reg_we_o  out  1; wb_wb_mux_sel_o  out  2; mem_err_o  out  1  -- all registered MEM/WB outputs.

Function
REQ-013 FSM states IDLE, REQ, RSP; only IDLE accepts a new instruction.
REQ-014 Non-memory valid instruction in IDLE: MEM/WB outputs loaded next edge (latency 1), no stall.
REQ-015 Load/store in IDLE: mem_stall_o high combinationally same cycle, dmem_req_o high, go REQ.
REQ-016 REQ: hold req/we/addr/wdata/be stable until dmem_gnt_i; store with gnt -> write MEM/WB, IDLE; load with gnt -> RSP.
REQ-017 RSP: dmem_req_o low; on dmem_rvalid_i load formatted data into wb_mem_rdata_o, IDLE; mem_stall_o drops the cycle rvalid is seen.
REQ-018 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half selected by addr[1:0], sign or zero extended to 32.
REQ-019 Stores: 000 SB be=0001<<addr[1:0], data byte replicated x4; 001 SH be=0011<<addr[1:0], half replicated x2; 010 SW be=1111.
REQ-020 Loads drive dmem_be_o per size as stores; dmem_addr_o = {addr[31:2],2'b00}.
REQ-021 Wait counter cleared on entering REQ, increments each REQ/RSP cycle; reaching MAX_WAIT aborts: IDLE, stall released, mem_err_o=1 one cycle, wb_reg_we_o=0.
REQ-022 Every cycle without a completed instruction (ex_valid_i=0, or stalled) writes a bubble: wb_reg_we_o=0, mem_err_o=0.
REQ-023 wb_reg_we_o = ex_reg_we_i only on completion without error; rd_addr x0 passed unchanged.
REQ-024 dmem_rvalid_i while in IDLE or REQ ignored; gnt and rvalid same cycle in REQ for a load: take gnt only, wait rvalid next.
REQ-025 Invalid funct3 on memory op: no request, mem_err_o=1 one cycle, reg_we 0.

Reset
REQ-026 rst: state IDLE, counter 0, every output 0, including mid-transaction; outstanding access abandoned, its later rvalid ignored.

Configuration
REQ-027 MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no request, mem_err_o=1 one cycle, wb_reg_we_o=0, no stall.
REQ-028 MEM_MISALIGN_TRAP_EN undefined: offending low address bits treated as 0 (natural alignment), access proceeds normally.

Verification
REQ-029 ADD result 0x12 rd=5 -> next cycle wb_alu_result_o=0x12, wb_rd_addr_o=5, wb_reg_we_o=1, no stall.
REQ-030 LB addr 0x103, gnt after 2 cycles, rvalid 1 later, rdata 0x80FFFFFF -> wb_mem_rdata_o=0xFFFFFF80, be=1000, stall 4 cycles.
REQ-031 SH addr 0x202 data 0x0000ABCD, gnt immediate -> be=1100, wdata=0xABCDABCD, dmem_we_o=1, completes in 1 cycle.
REQ-032 MAX_WAIT=4, load never granted -> after 4 cycles mem_err_o pulse, wb_reg_we_o=0, stall low.
REQ-033 LW addr 0x101 -> with macro: mem_err_o=1, dmem_req_o never high; without: dmem_addr_o=0x100, be=1111.
REQ-034 rst asserted while in RSP, stale rvalid next cycle -> outputs 0, state IDLE, no write-back.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory request/grant/response handshake, load formatting, MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_store_data_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_pc_plus4_i,
    input  logic        ex_reg_we_i,
    input  logic [1:0]  ex_wb_mux_sel_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_mem_write_i,
    input  logic [2:0]  ex_funct3_i,
    output logic        mem_stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] wb_mem_rdata_o,
    output logic [31:0] wb_alu_result_o,
    output logic [31:0] wb_pc_plus4_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic        wb_reg_we_o,
    output logic [1:0]  wb_wb_mux_sel_o,
    output logic        mem_err_o
);
    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        is_load, is_store, is_mem, f3_ok, bad;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata, shifted, load_data;
    logic        req, stall, complete, fail;

    // Access decode; EX/MEM inputs are held while stalled, so this stays valid for the whole access.
    always_comb begin
        is_load  = ex_mem_read_i;
        is_store = ex_mem_write_i & ~ex_mem_read_i;
        is_mem   = ex_valid_i & (is_load | is_store);
        case (ex_funct3_i)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = is_load;
            default:                f3_ok = 1'b0;
        endcase
        case (ex_funct3_i[1:0])
            2'b00: begin
                off   = ex_alu_result_i[1:0];
                be    = 4'b0001 << off;
                wdata = {4{ex_store_data_i[7:0]}};
            end
            2'b01: begin
                off   = {ex_alu_result_i[1], 1'b0};
                be    = 4'b0011 << off;
                wdata = {2{ex_store_data_i[15:0]}};
            end
            default: begin
                off   = 2'b00;
                be    = 4'b1111;
                wdata = ex_store_data_i;
            end
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        bad = ~f3_ok
            | ((ex_funct3_i[1:0] == 2'b01) & ex_alu_result_i[0])
            | ((ex_funct3_i[1:0] == 2'b10) & (ex_alu_result_i[1:0] != 2'b00));
`else
        bad = ~f3_ok;
`endif
        shifted = dmem_rdata_i >> {off, 3'b000};
        case (ex_funct3_i)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        fail     = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    if (is_mem) begin
                        if (bad) begin
                            fail = 1'b1;
                        end else begin
                            req = 1'b1;
                            if (is_store && dmem_gnt_i) begin
                                complete = 1'b1;
                            end else begin
                                stall   = 1'b1;
                                cnt_d   = '0;
                                state_d = dmem_gnt_i ? StRsp : StReq;
                            end
                        end
                    end else if (ex_valid_i) begin
                        complete = 1'b1;
                    end
                end
                StReq, StRsp: begin
                    req = (state_q == StReq);
                    if ((state_q == StReq && is_store && dmem_gnt_i) ||
                        (state_q == StRsp && dmem_rvalid_i)) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
                        // Timeout wins over a load grant arriving on the final allowed cycle.
                        fail    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + CntW'(1);
                        if (state_q == StReq && dmem_gnt_i) state_d = StRsp;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign mem_stall_o  = stall;
    assign dmem_req_o   = req;
    assign dmem_we_o    = req & is_store;
    assign dmem_addr_o  = req ? {ex_alu_result_i[31:2], 2'b00} : 32'b0;
    assign dmem_wdata_o = req ? wdata : 32'b0;
    assign dmem_be_o    = req ? be : 4'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            wb_mem_rdata_o  <= '0;
            wb_alu_result_o <= '0;
            wb_pc_plus4_o   <= '0;
            wb_rd_addr_o    <= '0;
            wb_reg_we_o     <= 1'b0;
            wb_wb_mux_sel_o <= '0;
            mem_err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_reg_we_o <= complete & ex_reg_we_i;
            mem_err_o   <= fail;
            if (complete) begin
                wb_mem_rdata_o  <= is_load ? load_data : 32'b0;
                wb_alu_result_o <= ex_alu_result_i;
                wb_pc_plus4_o   <= ex_pc_plus4_i;
                wb_rd_addr_o    <= ex_rd_addr_i;
                wb_wb_mux_sel_o <= ex_wb_mux_sel_i;
            end
        end
    end

endmodule
